// File: rtl/msi_coherence_fsm.sv
// Per-cache-block MSI snooping coherence controller: a requester FSM for local CPU
// actions and an independent snooper FSM for bus traffic, each with registered results.
module msi_coherence_fsm #(
    parameter int ID_W   = 2,
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              req_active,
    input  logic [2:0]        cpu_action,
    input  logic [1:0]        req_state_in,
    input  logic [ID_W-1:0]   proc_id,
    output logic              req_wb,
    output logic [1:0]        req_state_out,
    output logic [2:0]        bus_msg_out,
    output logic [ID_W-1:0]   req_proc,

    input  logic              snp_active,
    input  logic              snp_hit_in,
    input  logic [1:0]        snp_state_in,
    input  logic [2:0]        bus_msg_in,
    input  logic [DATA_W-1:0] snp_data_in,
    output logic              snp_wb,
    output logic              abort_mem,
    output logic              snp_hit,
    output logic [1:0]        snp_state_out,
    output logic [ID_W-1:0]   snp_proc,
    output logic [DATA_W-1:0] snp_data_out
);

    typedef enum logic [1:0] {
        BLK_I = 2'b00,
        BLK_S = 2'b01,
        BLK_M = 2'b10
    } blk_state_t;

    typedef enum logic [2:0] {
        MSG_NONE       = 3'b000,
        MSG_READ_MISS  = 3'b001,
        MSG_WRITE_MISS = 3'b010,
        MSG_INVALIDATE = 3'b011
    } bus_msg_t;

    typedef enum logic [2:0] {
        ACT_READ_HIT   = 3'b001,
        ACT_READ_MISS  = 3'b010,
        ACT_WRITE_HIT  = 3'b011,
        ACT_WRITE_MISS = 3'b100
    } cpu_action_t;

    // Encoding 11 is not a legal block state; it is folded onto I everywhere.
    function automatic blk_state_t decode_state(input logic [1:0] raw);
        case (raw)
            2'b01:   return BLK_S;
            2'b10:   return BLK_M;
            default: return BLK_I;
        endcase
    endfunction

    blk_state_t req_cur;
    blk_state_t req_next;
    bus_msg_t   req_msg_next;
    logic       req_wb_next;

    always_comb begin
        req_cur      = decode_state(req_state_in);
        req_next     = req_cur;
        req_msg_next = MSG_NONE;
        req_wb_next  = 1'b0;
        case (req_cur)
            BLK_I: begin
                // A hit on an invalid block cannot be serviced locally; treat as a miss.
                case (cpu_action)
                    ACT_READ_HIT, ACT_READ_MISS: begin
                        req_next     = BLK_S;
                        req_msg_next = MSG_READ_MISS;
                    end
                    ACT_WRITE_HIT, ACT_WRITE_MISS: begin
                        req_next     = BLK_M;
                        req_msg_next = MSG_WRITE_MISS;
                    end
                    default: ;
                endcase
            end
            BLK_S: begin
                case (cpu_action)
                    ACT_READ_MISS: begin
                        req_msg_next = MSG_READ_MISS;
                    end
                    ACT_WRITE_HIT: begin
                        req_next     = BLK_M;
                        req_msg_next = MSG_INVALIDATE;
                    end
                    ACT_WRITE_MISS: begin
                        req_next     = BLK_M;
                        req_msg_next = MSG_WRITE_MISS;
                    end
                    default: ;
                endcase
            end
            BLK_M: begin
                case (cpu_action)
                    ACT_READ_MISS: begin
                        req_next     = BLK_S;
                        req_msg_next = MSG_READ_MISS;
                        req_wb_next  = 1'b1;
                    end
                    ACT_WRITE_MISS: begin
                        req_msg_next = MSG_WRITE_MISS;
                        req_wb_next  = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    blk_state_t        snp_cur;
    blk_state_t        snp_next;
    logic              snp_hit_next;
    logic              snp_supply;

    always_comb begin
        snp_cur      = decode_state(snp_state_in);
        snp_next     = snp_cur;
        snp_hit_next = 1'b0;
        snp_supply   = 1'b0;
        if (snp_hit_in && (snp_cur != BLK_I)) begin
            snp_hit_next = 1'b1;
            case (bus_msg_in)
                MSG_READ_MISS: begin
                    snp_next   = BLK_S;
                    snp_supply = (snp_cur == BLK_M);
                end
                MSG_WRITE_MISS: begin
                    snp_next   = BLK_I;
                    snp_supply = (snp_cur == BLK_M);
                end
                MSG_INVALIDATE: begin
                    snp_next = BLK_I;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            req_wb        <= 1'b0;
            req_state_out <= '0;
            bus_msg_out   <= '0;
            req_proc      <= '0;
            snp_wb        <= 1'b0;
            abort_mem     <= 1'b0;
            snp_hit       <= 1'b0;
            snp_state_out <= '0;
            snp_proc      <= '0;
            snp_data_out  <= '0;
        end else begin
            if (req_active) begin
                req_wb        <= req_wb_next;
                req_state_out <= req_next;
                bus_msg_out   <= req_msg_next;
                req_proc      <= proc_id;
            end
            if (snp_active) begin
                snp_wb        <= snp_supply;
                abort_mem     <= snp_supply;
                snp_hit       <= snp_hit_next;
                snp_state_out <= snp_next;
                snp_proc      <= proc_id;
                snp_data_out  <= snp_supply ? snp_data_in : '0;
            end
        end
    end

endmodule

// File: tb/tb_msi_coherence_fsm.sv
// Bench for msi_coherence_fsm: directed vector table, reset corner cases, and
// randomized traffic checked against a rule-level MSI model.
module tb_msi_coherence_fsm;

    logic       clock = 1'b0;
    logic       reset;
    logic       req_active;
    logic [2:0] cpu_action;
    logic [1:0] req_state_in;
    logic [1:0] proc_id;
    logic       req_wb;
    logic [1:0] req_state_out;
    logic [2:0] bus_msg_out;
    logic [1:0] req_proc;
    logic       snp_active;
    logic       snp_hit_in;
    logic [1:0] snp_state_in;
    logic [2:0] bus_msg_in;
    logic [7:0] snp_data_in;
    logic       snp_wb;
    logic       abort_mem;
    logic       snp_hit;
    logic [1:0] snp_state_out;
    logic [1:0] snp_proc;
    logic [7:0] snp_data_out;

    msi_coherence_fsm #(.ID_W(2), .DATA_W(8)) dut (
        .clock(clock), .reset(reset),
        .req_active(req_active), .cpu_action(cpu_action), .req_state_in(req_state_in),
        .proc_id(proc_id), .req_wb(req_wb), .req_state_out(req_state_out),
        .bus_msg_out(bus_msg_out), .req_proc(req_proc),
        .snp_active(snp_active), .snp_hit_in(snp_hit_in), .snp_state_in(snp_state_in),
        .bus_msg_in(bus_msg_in), .snp_data_in(snp_data_in), .snp_wb(snp_wb),
        .abort_mem(abort_mem), .snp_hit(snp_hit), .snp_state_out(snp_state_out),
        .snp_proc(snp_proc), .snp_data_out(snp_data_out)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic       ra;
        logic [2:0] act;
        logic [1:0] rst;
        logic [1:0] pid;
        logic       sa;
        logic       hin;
        logic [1:0] sst;
        logic [2:0] msg;
        logic [7:0] data;
    } in_t;

    typedef struct packed {
        logic       rwb;
        logic [1:0] rstate;
        logic [2:0] bmsg;
        logic [1:0] rproc;
        logic       swb;
        logic       abort;
        logic       shit;
        logic [1:0] sstate;
        logic [1:0] sproc;
        logic [7:0] sdata;
    } exp_t;

    typedef struct {
        in_t  in;
        exp_t exp;
    } vec_t;

    int unsigned checks = 0;
    int unsigned passes = 0;
    int unsigned fails  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            passes++;
        end
    endtask

    task automatic check_all(input string tag, input exp_t e);
        chk({tag, ".req_wb"},        32'(req_wb),        32'(e.rwb));
        chk({tag, ".req_state_out"}, 32'(req_state_out), 32'(e.rstate));
        chk({tag, ".bus_msg_out"},   32'(bus_msg_out),   32'(e.bmsg));
        chk({tag, ".req_proc"},      32'(req_proc),      32'(e.rproc));
        chk({tag, ".snp_wb"},        32'(snp_wb),        32'(e.swb));
        chk({tag, ".abort_mem"},     32'(abort_mem),     32'(e.abort));
        chk({tag, ".snp_hit"},       32'(snp_hit),       32'(e.shit));
        chk({tag, ".snp_state_out"}, 32'(snp_state_out), 32'(e.sstate));
        chk({tag, ".snp_proc"},      32'(snp_proc),      32'(e.sproc));
        chk({tag, ".snp_data_out"},  32'(snp_data_out),  32'(e.sdata));
    endtask

    task automatic drive(input in_t v);
        req_active   = v.ra;
        cpu_action   = v.act;
        req_state_in = v.rst;
        proc_id      = v.pid;
        snp_active   = v.sa;
        snp_hit_in   = v.hin;
        snp_state_in = v.sst;
        bus_msg_in   = v.msg;
        snp_data_in  = v.data;
    endtask

    // Reference model: states as integers 0=I 1=S 2=M, derived from the protocol rules.
    function automatic exp_t model(input exp_t prev, input in_t v);
        exp_t e = prev;
        int s, a;
        bit wr, hit;
        if (v.ra) begin
            s = (v.rst == 2'd3) ? 0 : int'(v.rst);
            a = int'(v.act);
            e.rwb = 0; e.bmsg = 0; e.rstate = 2'(s); e.rproc = v.pid;
            if (a >= 1 && a <= 4) begin
                wr  = (a >= 3);
                hit = (a == 1 || a == 3) && (s != 0);
                if (hit) begin
                    if (wr && s == 1) begin e.rstate = 2; e.bmsg = 3; end
                    else if (wr) e.rstate = 2;
                end else begin
                    e.bmsg   = wr ? 3'd2 : 3'd1;
                    e.rstate = wr ? 2'd2 : 2'd1;
                    e.rwb    = (s == 2);
                end
            end
        end
        if (v.sa) begin
            s = (v.sst == 2'd3) ? 0 : int'(v.sst);
            e.sstate = 2'(s); e.shit = 0; e.swb = 0; e.abort = 0; e.sdata = 0;
            e.sproc = v.pid;
            if (v.hin && s != 0) begin
                e.shit = 1;
                if (v.msg == 3'd1) e.sstate = 1;
                else if (v.msg == 3'd2 || v.msg == 3'd3) e.sstate = 0;
                if ((v.msg == 3'd1 || v.msg == 3'd2) && s == 2) begin
                    e.swb = 1; e.abort = 1; e.sdata = v.data;
                end
            end
        end
        return e;
    endfunction

    vec_t vecs[13];
    exp_t cur;
    in_t  rv;

    initial begin
        // in:  ra act rst pid | sa hin sst msg data
        // exp: rwb rstate bmsg rproc | swb abort shit sstate sproc sdata
        vecs[0]  = '{in_t'{1,3'b010,2'd0,2'd2, 0,0,2'd0,3'd0,8'd0},  exp_t'{0,2'd1,3'd1,2'd2, 0,0,0,2'd0,2'd0,8'd0}};
        vecs[1]  = '{in_t'{0,3'b100,2'd2,2'd1, 0,0,2'd0,3'd0,8'd0},  exp_t'{0,2'd1,3'd1,2'd2, 0,0,0,2'd0,2'd0,8'd0}};
        vecs[2]  = '{in_t'{1,3'b011,2'd1,2'd1, 0,0,2'd0,3'd0,8'd0},  exp_t'{0,2'd2,3'd3,2'd1, 0,0,0,2'd0,2'd0,8'd0}};
        vecs[3]  = '{in_t'{1,3'b010,2'd2,2'd3, 0,0,2'd0,3'd0,8'd0},  exp_t'{1,2'd1,3'd1,2'd3, 0,0,0,2'd0,2'd0,8'd0}};
        vecs[4]  = '{in_t'{1,3'b001,2'd2,2'd0, 0,0,2'd0,3'd0,8'd0},  exp_t'{0,2'd2,3'd0,2'd0, 0,0,0,2'd0,2'd0,8'd0}};
        vecs[5]  = '{in_t'{0,3'b000,2'd0,2'd1, 1,1,2'd2,3'd1,8'd30}, exp_t'{0,2'd2,3'd0,2'd0, 1,1,1,2'd1,2'd1,8'd30}};
        vecs[6]  = '{in_t'{0,3'b000,2'd0,2'd1, 1,1,2'd2,3'd2,8'd30}, exp_t'{0,2'd2,3'd0,2'd0, 1,1,1,2'd0,2'd1,8'd30}};
        vecs[7]  = '{in_t'{0,3'b000,2'd0,2'd2, 1,1,2'd1,3'd2,8'd55}, exp_t'{0,2'd2,3'd0,2'd0, 0,0,1,2'd0,2'd2,8'd0}};
        vecs[8]  = '{in_t'{0,3'b000,2'd0,2'd2, 1,0,2'd1,3'd2,8'd55}, exp_t'{0,2'd2,3'd0,2'd0, 0,0,0,2'd1,2'd2,8'd0}};
        vecs[9]  = '{in_t'{1,3'b100,2'd0,2'd3, 1,1,2'd2,3'd3,8'd77}, exp_t'{0,2'd2,3'd2,2'd3, 0,0,1,2'd0,2'd3,8'd0}};
        vecs[10] = '{in_t'{1,3'b111,2'd1,2'd1, 0,1,2'd2,3'd1,8'd11}, exp_t'{0,2'd1,3'd0,2'd1, 0,0,1,2'd0,2'd3,8'd0}};
        vecs[11] = '{in_t'{1,3'b001,2'd3,2'd0, 1,1,2'd3,3'd1,8'd12}, exp_t'{0,2'd1,3'd1,2'd0, 0,0,0,2'd0,2'd0,8'd0}};
        vecs[12] = '{in_t'{1,3'b000,2'd3,2'd2, 1,1,2'd2,3'd0,8'd9},  exp_t'{0,2'd0,3'd0,2'd2, 0,0,1,2'd2,2'd2,8'd0}};

        reset = 1'b1;
        drive('0);
        #12;
        check_all("por", '0);
        reset = 1'b0;
        @(posedge clock); #1;
        check_all("post_reset_idle", '0);

        foreach (vecs[i]) begin
            drive(vecs[i].in);
            @(posedge clock); #1;
            check_all($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Asynchronous reset mid-cycle, held across an active edge, then released idle.
        drive(in_t'{1,3'b100,2'd1,2'd3, 1,1,2'd2,3'd1,8'hA5});
        @(posedge clock); #1;
        check_all("pre_reset", exp_t'{0,2'd2,3'd2,2'd3, 1,1,1,2'd1,2'd3,8'hA5});
        #2 reset = 1'b1;
        #1 check_all("async_reset", '0);
        @(posedge clock); #1;
        check_all("reset_held_active", '0);
        drive('0);
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1 check_all("reset_release_idle", '0);

        cur = '0;
        for (int n = 0; n < 400; n++) begin
            rv = in_t'($urandom());
            rv.data = 8'($urandom());
            drive(rv);
            cur = model(cur, rv);
            @(posedge clock); #1;
            check_all($sformatf("rnd%0d", n), cur);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
